// File: rtl/spdif_frame_assemble.sv
// S/PDIF transmit frame assembler: holds one sample per channel and emits
// biphase-mark coded 32-slot subframes at one half-cell per clock.
//
// Ports:
//   clk, rst       - audio clock, synchronous active-high reset
//   din, vin       - 20-bit sample and its valid strobe
//   channel        - 0 = A (left), 1 = B (right)
//   cstat          - 192-bit channel-status block, latched at frame 0
//   dout           - registered biphase-mark line output
//   frame_counter  - current frame index 0..191
//   out_channel    - subframe currently on the line
//   underrun       - sticky: subframe sent without a fresh sample
//   overflow       - sticky: held sample overwritten before it was sent

module spdif_frame_assemble (
  input  logic         clk,
  input  logic         rst,
  input  logic [19:0]  din,
  input  logic         vin,
  input  logic         channel,
  input  logic [191:0] cstat,
  output logic         dout,
  output logic [7:0]   frame_counter,
  output logic         out_channel,
  output logic         underrun,
  output logic         overflow
);

  typedef enum logic [1:0] {
    PRE_B,
    PRE_M,
    PRE_W
  } pre_e;

  logic [5:0]   hc_q, hc_d;
  logic         sub_q, sub_d;
  logic [7:0]   frame_q, frame_d;
  logic [19:0]  hold_a_q, hold_a_d;
  logic [19:0]  hold_b_q, hold_b_d;
  logic         full_a_q, full_a_d;
  logic         full_b_q, full_b_d;
  logic         primed_q, primed_d;
  logic         underrun_q, underrun_d;
  logic         overflow_q, overflow_d;
  logic [191:0] cstat_q, cstat_d;
  logic [27:0]  slot_q, slot_d;
  logic         dout_q, dout_d;
  logic         och_q, och_d;

  logic         load;
  logic         last_hc;
  logic         wr_a, wr_b;
  logic         cons_a, cons_b;
  logic         ld_full;
  logic [19:0]  ld_data;
  logic [19:0]  audio;
  logic         v_bit;
  logic         c_bit;
  logic [191:0] cstat_eff;
  logic [26:0]  body;
  logic [4:0]   slot_idx;
  pre_e         pre_sel;
  logic [7:0]   pre;

  assign load    = (hc_q == 6'd0);
  assign last_hc = (hc_q == 6'd63);
  assign wr_a    = vin & ~channel;
  assign wr_b    = vin & channel;
  assign cons_a  = load & ~sub_q;
  assign cons_b  = load & sub_q;

  // Preamble kind for the subframe in progress
  always_comb begin
    pre_sel = PRE_M;
    priority case (1'b1)
      sub_q:            pre_sel = PRE_W;
      frame_q == 8'd0:  pre_sel = PRE_B;
      default:          pre_sel = PRE_M;
    endcase
  end

  always_comb begin
    pre = 8'b11100010;
    unique case (pre_sel)
      PRE_B:   pre = 8'b11101000;
      PRE_W:   pre = 8'b11100100;
      default: pre = 8'b11100010;
    endcase
  end

  // Counters
  always_comb begin
    hc_d    = hc_q + 6'd1;
    sub_d   = sub_q;
    frame_d = frame_q;
    if (last_hc) begin
      sub_d = ~sub_q;
      if (sub_q) begin
        if (frame_q == 8'd191) frame_d = 8'd0;
        else                   frame_d = frame_q + 8'd1;
      end
    end
  end

  // Holding registers; a load in the same cycle as a write takes the old
  // contents and leaves the new sample held.
  always_comb begin
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    full_a_d   = full_a_q;
    full_b_d   = full_b_q;
    overflow_d = overflow_q;
    primed_d   = primed_q | vin;
    if (cons_a) full_a_d = 1'b0;
    if (cons_b) full_b_d = 1'b0;
    if (wr_a) begin
      hold_a_d = din;
      full_a_d = 1'b1;
      if (full_a_q && !cons_a) overflow_d = 1'b1;
    end
    if (wr_b) begin
      hold_b_d = din;
      full_b_d = 1'b1;
      if (full_b_q && !cons_b) overflow_d = 1'b1;
    end
  end

  // Subframe load: slots 4..31 captured once at hc==0
  always_comb begin
    ld_full    = sub_q ? full_b_q : full_a_q;
    ld_data    = sub_q ? hold_b_q : hold_a_q;
    cstat_eff  = cstat_q;
    if (cons_a && frame_q == 8'd0) cstat_eff = cstat;
    cstat_d    = cstat_eff;
    audio      = ld_full ? ld_data : 20'd0;
    v_bit      = ~ld_full;
    c_bit      = cstat_eff[frame_q];
    body       = {c_bit, 1'b0, v_bit, audio, 4'b0000};
    slot_d     = slot_q;
    underrun_d = underrun_q;
    if (load) begin
      slot_d = {^body, body};
      if (!ld_full && primed_q) underrun_d = 1'b1;
    end
  end

  // Biphase-mark encoder: every data slot starts with a transition, a one
  // adds another in the middle. dout_q is the previous half-cell level.
  always_comb begin
    slot_idx = hc_q[5:1] - 5'd4;
    och_d    = sub_q;
    if (hc_q < 6'd8)  dout_d = pre[3'd7 - hc_q[2:0]];
    else if (!hc_q[0]) dout_d = ~dout_q;
    else               dout_d = dout_q ^ slot_q[slot_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q       <= '0;
      sub_q      <= 1'b0;
      frame_q    <= '0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      full_a_q   <= 1'b0;
      full_b_q   <= 1'b0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      cstat_q    <= '0;
      slot_q     <= '0;
      dout_q     <= 1'b0;
      och_q      <= 1'b0;
    end else begin
      hc_q       <= hc_d;
      sub_q      <= sub_d;
      frame_q    <= frame_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      full_a_q   <= full_a_d;
      full_b_q   <= full_b_d;
      primed_q   <= primed_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      cstat_q    <= cstat_d;
      slot_q     <= slot_d;
      dout_q     <= dout_d;
      och_q      <= och_d;
    end
  end

  // Even parity must bring the line back to 0 at every subframe boundary
  a_level_zero: assert property (
    @(posedge clk) disable iff (rst) (hc_q == 6'd0) |-> !dout_q
  );

  assign dout          = dout_q;
  assign frame_counter = frame_q;
  assign out_channel   = och_q;
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_spdif_frame_assemble.sv
// Directed bench for spdif_frame_assemble: captures whole subframes of
// line half-cells and decodes them against hand-computed values.

module tb_spdif_frame_assemble;

  logic         clk;
  logic         rst;
  logic [19:0]  din;
  logic         vin;
  logic         channel;
  logic [191:0] cstat;
  logic         dout;
  logic [7:0]   frame_counter;
  logic         out_channel;
  logic         underrun;
  logic         overflow;

  int n_chk;
  int n_err;
  logic [7:0] cap_fc;
  logic       cap_oc;

  spdif_frame_assemble dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .vin(vin),
    .channel(channel),
    .cstat(cstat),
    .dout(dout),
    .frame_counter(frame_counter),
    .out_channel(out_channel),
    .underrun(underrun),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [191:0] cs);
    cstat   = cs;
    rst     = 1'b1;
    vin     = 1'b0;
    channel = 1'b0;
    din     = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // wm[0]: A=v0 at hc 32, wm[1]: B=v1 at hc 33, wm[2]: A=v2 at hc 40
  task automatic run_sub(input logic [2:0] wm, input logic [19:0] v0,
                         input logic [19:0] v1, input logic [19:0] v2,
                         output logic [63:0] hcs);
    hcs = '0;
    for (int h = 0; h < 64; h++) begin
      vin = 1'b0; channel = 1'b0; din = '0;
      if (h == 32 && wm[0]) begin vin = 1'b1; channel = 1'b0; din = v0; end
      if (h == 33 && wm[1]) begin vin = 1'b1; channel = 1'b1; din = v1; end
      if (h == 40 && wm[2]) begin vin = 1'b1; channel = 1'b0; din = v2; end
      tick();
      hcs[h] = dout;
      if (h == 0) begin
        cap_fc = frame_counter;
        cap_oc = out_channel;
      end
    end
    vin = 1'b0;
  endtask

  function automatic logic sbit(input logic [63:0] h, input int k);
    return h[2*k] ^ h[2*k+1];
  endfunction

  function automatic logic [7:0] pre_of(input logic [63:0] h);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[7-i] = h[i];
    return p;
  endfunction

  function automatic logic [19:0] audio_of(input logic [63:0] h);
    logic [19:0] a;
    for (int k = 0; k < 20; k++) a[k] = sbit(h, 8 + k);
    return a;
  endfunction

  function automatic logic [3:0] aux_of(input logic [63:0] h);
    logic [3:0] a;
    for (int k = 0; k < 4; k++) a[k] = sbit(h, 4 + k);
    return a;
  endfunction

  function automatic logic par_of(input logic [63:0] h);
    logic p;
    p = 1'b0;
    for (int k = 4; k < 32; k++) p ^= sbit(h, k);
    return p;
  endfunction

  logic [63:0]  hs;
  logic [19:0]  a_prev;
  logic [191:0] cs5;
  int           n_b;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1; vin = 1'b0; channel = 1'b0; din = '0; cstat = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_dout", dout, 0);
    chk("rst_fc", frame_counter, 0);
    chk("rst_och", out_channel, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_ov", overflow, 0);

    // No input after reset
    do_reset('0);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t1_pre", pre_of(hs), 8'hE8);
    chk("t1_aux", aux_of(hs), 0);
    chk("t1_audio", audio_of(hs), 0);
    chk("t1_v", sbit(hs, 28), 1);
    chk("t1_p", sbit(hs, 31), 1);
    chk("t1_level", hs[63], 0);
    chk("t1_ur", underrun, 0);
    chk("t1_och", cap_oc, 0);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t1_pre_w", pre_of(hs), 8'hE4);
    chk("t1_och_b", cap_oc, 1);

    // Single sample A=1
    do_reset('0);
    run_sub(3'b011, 20'h00001, 20'h00000, 0, hs);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t2_b0_pre", pre_of(hs), 8'hE4);
    chk("t2_b0_v", sbit(hs, 28), 0);
    chk("t2_b0_audio", audio_of(hs), 0);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t2_pre_m", pre_of(hs), 8'hE2);
    chk("t2_s8_edge", hs[16] ^ hs[15], 1);
    chk("t2_s8_bit", sbit(hs, 8), 1);
    chk("t2_audio", audio_of(hs), 20'h00001);
    chk("t2_v", sbit(hs, 28), 0);
    chk("t2_p", sbit(hs, 31), 1);
    chk("t2_level", hs[63], 0);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t2_pre_w", pre_of(hs), 8'hE4);

    // Continuous streaming over 400 frames, cstat bit 5 only
    cs5 = '0;
    cs5[5] = 1'b1;
    do_reset(cs5);
    n_b = 0;
    a_prev = '0;
    for (int s = 0; s < 800; s++) begin
      int f;
      logic [19:0] va;
      logic [19:0] vb;
      f  = s / 2;
      va = 20'(f * 37 + 1);
      vb = 20'(f * 91 + 5) ^ 20'hA5A5A;
      if (s % 2 == 0) begin
        run_sub(3'b011, va, vb, 0, hs);
        if (f > 0) chk("t3_audio_a", audio_of(hs), a_prev);
        a_prev = va;
      end else begin
        run_sub(3'b000, 0, 0, 0, hs);
        chk("t3_audio_b", audio_of(hs), vb);
      end
      if (pre_of(hs) == 8'hE8) n_b++;
      if (s % 2 == 1)          chk("t3_pre", pre_of(hs), 8'hE4);
      else if (f % 192 == 0)   chk("t3_pre", pre_of(hs), 8'hE8);
      else                     chk("t3_pre", pre_of(hs), 8'hE2);
      chk("t3_c", sbit(hs, 30), (f % 192 == 5) ? 1 : 0);
      chk("t3_fc", cap_fc, f % 192);
      chk("t3_och", cap_oc, s % 2);
      chk("t3_par", par_of(hs), 0);
      chk("t3_level", hs[63], 0);
    end
    chk("t3_nb", n_b, 3);
    chk("t3_ur", underrun, 0);
    chk("t3_ov", overflow, 0);

    // Overflow: two A writes within one frame
    do_reset('0);
    run_sub(3'b101, 20'h12345, 0, 20'h0ABCD, hs);
    chk("t4_ov", overflow, 1);
    run_sub(3'b000, 0, 0, 0, hs);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t4_audio", audio_of(hs), 20'h0ABCD);
    chk("t4_v", sbit(hs, 28), 0);

    // Underrun: skip one B write
    do_reset('0);
    run_sub(3'b011, 20'h11111, 20'h22222, 0, hs);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t5_b0", audio_of(hs), 20'h22222);
    run_sub(3'b001, 20'h33333, 0, 0, hs);
    chk("t5_a1", audio_of(hs), 20'h11111);
    chk("t5_ur0", underrun, 0);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t5_b1_audio", audio_of(hs), 0);
    chk("t5_b1_v", sbit(hs, 28), 1);
    chk("t5_b1_p", sbit(hs, 31), 1);
    chk("t5_ur1", underrun, 1);
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t5_a2_audio", audio_of(hs), 20'h33333);
    chk("t5_a2_v", sbit(hs, 28), 0);

    // Reset at hc 30 with a sample held
    for (int h = 0; h < 30; h++) begin
      vin = (h == 10);
      channel = 1'b0;
      din = 20'h55555;
      tick();
    end
    vin = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_dout", dout, 0);
    chk("t6_ur", underrun, 0);
    chk("t6_ov", overflow, 0);
    chk("t6_fc", frame_counter, 0);
    rst = 1'b0;
    run_sub(3'b000, 0, 0, 0, hs);
    chk("t6_pre", pre_of(hs), 8'hE8);
    chk("t6_audio", audio_of(hs), 0);
    chk("t6_v", sbit(hs, 28), 1);
    chk("t6_ur_after", underrun, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
